// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: drains four show-ahead input FIFOs into four destination
// output FIFOs, one word per cycle, with round-robin lane selection and
// per-lane starvation flags.
// Optional build macro: ARB_LANE0_PRIORITY_EN (lane 0 gets strict priority,
// lanes 1-3 round-robin among themselves).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | datapath inactive; no grants, counters and rr_ptr hold
// RUN   | scheduling; grants issued while active=1
module fifo_rr_arbiter #(
   parameter int DATA_WIDTH   = 6,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    active,
   input  logic [3:0]              in_empty,
   input  logic [4*DATA_WIDTH-1:0] in_data,
   input  logic [3:0]              out_almost_full,
   output logic [3:0]              in_pop,
   output logic [3:0]              out_push,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [1:0]              grant,
   output logic                    busy,
   output logic [3:0]              starve
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      rr_ptr;
   logic [3:0]      wait_cnt [4];
   logic [1:0]      dest [4];
   logic [3:0]      elig;
   logic            gnt_vld;
   logic [1:0]      gnt_idx;
   logic [DATA_WIDTH-1:0] head_word;

   // Destination field and eligibility of each lane's head word
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dest[i] = in_data[i*DATA_WIDTH + DATA_WIDTH - 1 -: 2];
         elig[i] = !in_empty[i] && !out_almost_full[dest[i]];
      end
   end

   // Lane selection: first eligible lane starting at rr_ptr
   always_comb begin
      logic [1:0] lane;
      gnt_vld = 1'b0;
      gnt_idx = 2'd0;
      lane    = 2'd0;
      if (!rst && active && state == RUN) begin
`ifdef ARB_LANE0_PRIORITY_EN
         if (elig[0]) begin
            gnt_vld = 1'b1;
            gnt_idx = 2'd0;
         end
         for (int k = 0; k < 4; k++) begin
            lane = rr_ptr + 2'(k);
            if (!gnt_vld && lane != 2'd0 && elig[lane]) begin
               gnt_vld = 1'b1;
               gnt_idx = lane;
            end
         end
`else
         for (int k = 0; k < 4; k++) begin
            lane = rr_ptr + 2'(k);
            if (!gnt_vld && elig[lane]) begin
               gnt_vld = 1'b1;
               gnt_idx = lane;
            end
         end
`endif
      end
   end

   assign in_pop    = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
   assign busy      = gnt_vld;
   assign head_word = in_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: RUN tracks active, checked against registered state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (active)  state_nxt = RUN;
         RUN:     if (!active) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output register stage and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         out_push <= 4'b0000;
         out_data <= '0;
         grant    <= 2'd0;
         rr_ptr   <= 2'd0;
      end else begin
         out_push <= gnt_vld ? (4'b0001 << dest[gnt_idx]) : 4'b0000;
         if (gnt_vld) begin
            out_data <= head_word;
            grant    <= gnt_idx;
`ifdef ARB_LANE0_PRIORITY_EN
            if (gnt_idx != 2'd0) rr_ptr <= gnt_idx + 2'd1;
`else
            rr_ptr <= gnt_idx + 2'd1;
`endif
         end
      end
   end

   // Per-lane wait counters and sticky starvation flags, frozen outside RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= 4'b0000;
         for (int i = 0; i < 4; i++) wait_cnt[i] <= 4'd0;
      end else if (state == RUN) begin
         for (int i = 0; i < 4; i++) begin
            if (in_pop[i]) begin
               wait_cnt[i] <= 4'd0;
               starve[i]   <= 1'b0;
            end else if (in_empty[i]) begin
               wait_cnt[i] <= 4'd0;
            end else begin
               if (wait_cnt[i] != 4'hF) wait_cnt[i] <= wait_cnt[i] + 4'd1;
               if (wait_cnt[i] == 4'hF || (wait_cnt[i] + 4'd1) >= LIMIT)
                  starve[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model every cycle.
module tb_fifo_rr_arbiter;

   localparam int DW    = 6;
   localparam int LIMIT = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          active = 1'b0;
   logic [3:0]    in_empty = 4'hF;
   logic [4*DW-1:0] in_data = '0;
   logic [3:0]    out_almost_full = 4'h0;
   logic [3:0]    in_pop;
   logic [3:0]    out_push;
   logic [DW-1:0] out_data;
   logic [1:0]    grant;
   logic          busy;
   logic [3:0]    starve;

   fifo_rr_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .active(active), .in_empty(in_empty),
      .in_data(in_data), .out_almost_full(out_almost_full),
      .in_pop(in_pop), .out_push(out_push), .out_data(out_data),
      .grant(grant), .busy(busy), .starve(starve)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   bit  m_run;
   int  m_ptr, m_grant, m_push, m_data, m_starve;
   int  m_cnt [4];
   logic [3:0] last_pop;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int word_of(input logic [4*DW-1:0] d, input int i);
      return int'((d >> (i*DW)) & ((1 << DW) - 1));
   endfunction

   function automatic int pick(input logic [3:0] e, input logic [4*DW-1:0] d,
                               input logic [3:0] f, input int ptr);
      bit el [4];
      for (int i = 0; i < 4; i++)
         el[i] = !e[i] && !f[word_of(d, i) >> (DW-2)];
`ifdef ARB_LANE0_PRIORITY_EN
      if (el[0]) return 0;
      for (int k = 0; k < 4; k++)
         if (((ptr + k) % 4) != 0 && el[(ptr + k) % 4]) return (ptr + k) % 4;
`else
      for (int k = 0; k < 4; k++)
         if (el[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
      return -1;
   endfunction

   task automatic step(input logic a, input logic r, input logic [3:0] e,
                       input logic [4*DW-1:0] d, input logic [3:0] f);
      int g, exp_pop;
      @(negedge clk);
      active = a; rst = r; in_empty = e; in_data = d; out_almost_full = f;
      #1;
      g = (!r && m_run && a) ? pick(e, d, f, m_ptr) : -1;
      exp_pop = (g >= 0) ? (1 << g) : 0;
      chk("in_pop", int'(in_pop), exp_pop);
      chk("busy", int'(busy), (g >= 0) ? 1 : 0);
      last_pop = in_pop;
      @(posedge clk);
      #1;
      if (r) begin
         m_run = 0; m_ptr = 0; m_grant = 0; m_push = 0; m_data = 0; m_starve = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
         m_push = (g >= 0) ? (1 << (word_of(d, g) >> (DW-2))) : 0;
         if (g >= 0) begin
            m_data  = word_of(d, g);
            m_grant = g;
`ifdef ARB_LANE0_PRIORITY_EN
            if (g != 0) m_ptr = (g + 1) % 4;
`else
            m_ptr = (g + 1) % 4;
`endif
         end
         if (m_run) begin
            for (int i = 0; i < 4; i++) begin
               if (g == i) begin
                  m_cnt[i] = 0;
                  m_starve &= ~(1 << i);
               end else if (e[i]) begin
                  m_cnt[i] = 0;
               end else begin
                  m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
                  if (m_cnt[i] >= LIMIT) m_starve |= (1 << i);
               end
            end
         end
         m_run = a;
      end
      chk("out_push", int'(out_push), m_push);
      chk("grant", int'(grant), m_grant);
      chk("starve", int'(starve), m_starve);
      if (m_push != 0) chk("out_data", int'(out_data), m_data);
   endtask

   function automatic logic [4*DW-1:0] mk(input int d0, d1, d2, d3);
      logic [4*DW-1:0] v;
      int dd [4];
      dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
      v = '0;
      for (int i = 0; i < 4; i++)
         v[i*DW +: DW] = DW'((dd[i] << (DW-2)) | ((i * 5 + 3) & ((1 << (DW-2)) - 1)));
      return v;
   endfunction

   initial begin
      logic [4*DW-1:0] d;
      int gseq [5];
      int exp_seq [5];
      exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 0;

      // reset
      step(0, 1, 4'hF, '0, 4'h0);
      step(0, 1, 4'hF, '0, 4'h0);
      chk("reset_grant", int'(grant), 0);
      chk("reset_starve", int'(starve), 0);
      chk("reset_push", int'(out_push), 0);

      // all lanes non-empty, distinct dests
      d = mk(1, 2, 3, 0);
      step(1, 0, 4'h0, d, 4'h0);
      chk("idle_to_run_no_pop", int'(last_pop), 0);
      for (int k = 0; k < 5; k++) begin
         step(1, 0, 4'h0, d, 4'h0);
         gseq[k] = int'(grant);
         if (k == 0) chk("first_push_onehot", int'(out_push), 2);
      end
      for (int k = 0; k < 5; k++) chk("rr_sequence", gseq[k], exp_seq[k]);

      // lane 1 blocked by almost-full destination 2
      d = mk(0, 2, 3, 0);
      for (int k = 0; k < 18; k++) step(1, 0, 4'b1000, d, 4'b0100);
      chk("lane1_starved", int'(starve[1]), 1);
      chk("lanes02_not_starved", int'(starve & 4'b0101), 0);
      for (int k = 0; k < 3; k++) step(1, 0, 4'b1000, d, 4'b0000);
      chk("lane1_starve_cleared", int'(starve[1]), 0);

      // only lane 3 non-empty
      d = mk(0, 0, 0, 2);
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 4'b0111, d, 4'h0);
         chk("lane3_pop", int'(last_pop), 8);
      end
      step(1, 0, 4'hF, d, 4'h0);

      // active drops while streaming
      d = mk(3, 2, 1, 0);
      for (int k = 0; k < 3; k++) step(1, 0, 4'h0, d, 4'h0);
      step(0, 0, 4'h0, d, 4'h0);
      chk("drop_no_pop", int'(last_pop), 0);
      step(0, 0, 4'h0, d, 4'h0);
      step(1, 0, 4'h0, d, 4'h0);
      chk("idle_after_drop", int'(last_pop), 0);

      // reset the cycle after a grant
      step(1, 0, 4'h0, d, 4'h0);
      step(1, 1, 4'h0, d, 4'h0);
      chk("rst_push_cleared", int'(out_push), 0);
      step(1, 0, 4'h0, d, 4'h0);
      step(1, 0, 4'h0, d, 4'h0);
      chk("post_rst_first_lane0", int'(last_pop), 1);

`ifdef ARB_LANE0_PRIORITY_EN
      d = mk(0, 0, 1, 0);
      for (int k = 0; k < 18; k++) begin
         step(1, 0, 4'b1010, d, 4'h0);
         chk("prio_lane0", int'(last_pop), 1);
      end
      chk("prio_lane2_starve", int'(starve[2]), 1);
`endif

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         logic a, r;
         logic [3:0] e, f;
         a = ($urandom_range(0, 19) != 0);
         r = ($urandom_range(0, 199) == 0);
         e = 4'($urandom) & 4'($urandom);
         f = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         d = (4*DW)'($urandom);
         step(a, r, e, d, f);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin scheduler that drains four show-ahead input FIFOs into four destination output FIFOs, one word per cycle. It runs while the flow-control FSM reports the datapath active. It picks the next eligible lane, pops it, and routes the word to the output FIFO selected by the word's destination field. Lanes are skipped while their destination FIFO is almost-full, and per-lane starvation flags are raised for lanes that wait too long.

## Interface
- `DATA_WIDTH`, 6: word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination index.
- `STARVE_LIMIT`, 15: consecutive blocked cycles before a lane's starve flag sets; counter width is 4 bits, legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `active`  in  1  scheduling enable from the flow-control FSM.
- `in_empty`  in  4  empty flag of input FIFO i.
- `in_data`  in  4*DATA_WIDTH  head word of FIFO i at bits [i*DATA_WIDTH +: DATA_WIDTH], valid while `in_empty[i]`=0.
- `out_almost_full`  in  4  almost-full flag of output FIFO d.
- `in_pop`  out  4  one-hot pop, combinational, same cycle as grant.
- `out_push`  out  4  one-hot push to output FIFO d, registered.
- `out_data`  out  DATA_WIDTH  word being pushed, registered.
- `grant`  out  2  index of the last granted lane, registered.
- `busy`  out  1  high in every cycle where `in_pop`≠0.
- `starve`  out  4  sticky per-lane starvation flag.

## Operation
- States: IDLE and RUN.
  - IDLE -> RUN when `active`=1.
  - RUN -> IDLE when `active`=0.
  - The RUN->IDLE check uses the registered state. The cycle in which `active` falls still evaluates in RUN but grants nothing: grants require `active`=1 and state RUN.
- Destination of lane i: `dest_i` = top 2 bits of lane i's head word.
- Eligibility: `elig[i]` = !`in_empty[i]` && !`out_almost_full[dest_i]`.
- Selection: first eligible lane searching `rr_ptr`, `rr_ptr`+1, ... mod 4. `rr_ptr` resets to 0.
- On grant of lane g:
  - `in_pop[g]`=1 in the same cycle.
  - At the next edge: `out_data` <= head word, `out_push` <= one-hot(`dest_g`), `grant` <= g, `rr_ptr` <= (g+1) mod 4.
- No eligible lane: `in_pop`=0, `out_push` registers 0, `rr_ptr` and `grant` hold.
- Starvation, per lane:
  - Wait counter increments (saturating at 15) each RUN cycle where the lane is non-empty and not granted.
  - Counter clears when the lane is granted or empty.
  - `starve[i]` sets when the counter reaches `STARVE_LIMIT`, and clears only when lane i is granted.
- Counters and `rr_ptr` hold in IDLE.
- Reset values: state IDLE, `out_push`=0, `out_data`=0, `grant`=0, `rr_ptr`=0, `starve`=0, all wait counters 0. `in_pop`=0 and `busy`=0 while `rst`=1.

## Timing
- Pop-to-push latency: exactly 1 cycle. Word popped in cycle t appears on `out_data`/`out_push` in cycle t+1 for one cycle.
- Throughput: at most one grant per cycle; back-to-back grants are allowed, including to the same lane.
- `out_almost_full` is sampled in the grant cycle. Because the push lands one cycle later, output FIFO thresholds must reserve at least 2 free slots. The arbiter does not check full.
- `active` falling at cycle t:
  - No pop at t.
  - A push already registered from t-1 still occurs at t.
- `rst` mid-operation:
  - A push registered before reset is discarded; `out_push` is 0 in the cycle after the `rst` edge.
  - Popped-but-unpushed words are lost, which is acceptable because reset also clears the FIFOs.
- Wrap-around: grant of lane 3 sets `rr_ptr` to 0.
- Simultaneous events:
  - A lane granted in the same cycle its counter would reach the limit clears its counter and does not set `starve`.

## Configuration
- `ARB_LANE0_PRIORITY_EN` defined:
  - Lane 0, when eligible, always wins.
  - `rr_ptr` does not advance on lane-0 grants.
  - Lanes 1-3 round-robin among themselves when lane 0 is not eligible.
- Undefined: pure 4-lane round-robin as described above.

## Test plan
- Reset, then `active`=1, all four lanes non-empty with distinct dests, no almost-full -> grants 0,1,2,3,0; `out_push` one-hot matches each dest one cycle after its pop.
- Lane 1 head dest=2, `out_almost_full[2]`=1, lanes 0 and 2 non-empty -> grant sequence skips lane 1. Lane 1 `starve` sets after 15 blocked RUN cycles and clears on its first grant after `out_almost_full[2]` drops.
- Single lane 3 non-empty for 3 cycles -> `in_pop`=4'b1000 three consecutive cycles; `rr_ptr` wraps to 0; three pushes, each 1 cycle delayed.
- `active` drops while grants are streaming -> no `in_pop` from that cycle on; the one pending push still appears; state returns to IDLE.
- `rst` asserted the cycle after a grant -> `out_push`=0, `starve`=0, `grant`=0 after the edge; the first grant after release is lane 0.
- With `ARB_LANE0_PRIORITY_EN`, lanes 0 and 2 continuously non-empty -> lane 0 granted every cycle; lane 2 `starve` sets after `STARVE_LIMIT` cycles.
